// File: rtl/gate_vector_checker_if.sv
// Signal bundle between the gate vector checker and its environment
// (the gate under test plus whoever starts sweeps and reads results).
interface gate_vector_checker_if;
    logic       start;
    logic       vec_a;
    logic       vec_b;
    logic       vec_c;
    logic       resp_x;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic       fail_valid;
    logic [2:0] fail_vec;

    modport master (
        input  start, resp_x,
        output vec_a, vec_b, vec_c, busy, done, pass, err_count, fail_valid, fail_vec
    );

    modport slave (
        output start, resp_x,
        input  vec_a, vec_b, vec_c, busy, done, pass, err_count, fail_valid, fail_vec
    );
endinterface

// File: rtl/gate_vector_checker.sv
// Sweeps all eight {a,b,c} vectors into a 3-input gate and judges its response
// against a truth table. Define GATE_CHK_STOP_ON_FAIL_EN to stop at the first mismatch.
module gate_vector_checker #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [7:0]  EXPECT      = 8'b0000_1000
) (
    input logic                   clk,
    input logic                   rst,
    gate_vector_checker_if.master bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    // DRIVE covers HOLD_CYCLES-1 cycles, SAMPLE the last one.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 2);

    state_t     state, state_nxt;
    logic [2:0] vec, vec_nxt;
    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic [3:0] err_cnt, err_cnt_nxt;
    logic       fail_valid, fail_valid_nxt;
    logic [2:0] fail_vec, fail_vec_nxt;
    logic       pass, pass_nxt;
    logic       busy, done;
    logic       mismatch;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= 3'd0;
            hold_cnt   <= 8'd0;
            err_cnt    <= 4'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 3'd0;
            pass       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            hold_cnt   <= hold_cnt_nxt;
            err_cnt    <= err_cnt_nxt;
            fail_valid <= fail_valid_nxt;
            fail_vec   <= fail_vec_nxt;
            pass       <= pass_nxt;
            busy       <= (state_nxt == DRIVE) || (state_nxt == SAMPLE);
            done       <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt      = state;
        vec_nxt        = vec;
        hold_cnt_nxt   = hold_cnt;
        err_cnt_nxt    = err_cnt;
        fail_valid_nxt = fail_valid;
        fail_vec_nxt   = fail_vec;
        pass_nxt       = pass;
        mismatch       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt      = DRIVE;
                    vec_nxt        = 3'd0;
                    hold_cnt_nxt   = 8'd0;
                    err_cnt_nxt    = 4'd0;
                    fail_valid_nxt = 1'b0;
                    fail_vec_nxt   = 3'd0;
                    pass_nxt       = 1'b0;
                end
            end
            DRIVE: begin
                hold_cnt_nxt = hold_cnt + 8'd1;
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                mismatch = (bus.resp_x != EXPECT[vec]);
                if (mismatch) begin
                    err_cnt_nxt = sat_inc(err_cnt);
                    if (!fail_valid) begin
                        fail_valid_nxt = 1'b1;
                        fail_vec_nxt   = vec;
                    end
                end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                if (mismatch) begin
                    state_nxt = DONE;
                    pass_nxt  = 1'b0;
                end else if (vec == 3'd7) begin
`else
                if (vec == 3'd7) begin
`endif
                    state_nxt = DONE;
                    pass_nxt  = (err_cnt_nxt == 4'd0);
                end else begin
                    state_nxt    = DRIVE;
                    vec_nxt      = vec + 3'd1;
                    hold_cnt_nxt = 8'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.vec_a      = vec[2];
    assign bus.vec_b      = vec[1];
    assign bus.vec_c      = vec[0];
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.pass       = pass;
    assign bus.err_count  = err_cnt;
    assign bus.fail_valid = fail_valid;
    assign bus.fail_vec   = fail_vec;
endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: golden, stuck-at, short hold,
// reset mid-sweep and start-handling scenarios with hand-computed results.
module tb_gate_vector_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode = 0;   // 0 golden gate, 1 stuck-at-0, 2 stuck-at-1
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    gate_vector_checker_if b0();
    gate_vector_checker_if b1();

    assign b0.resp_x = (mode == 0) ? ((b0.vec_a ^ b0.vec_b) & ~(b0.vec_b ^ b0.vec_c) & b0.vec_c)
                                   : (mode == 2);
    assign b1.resp_x = (b1.vec_a ^ b1.vec_b) & ~(b1.vec_b ^ b1.vec_c) & b1.vec_c;

    gate_vector_checker dut0 (.clk(clk), .rst(rst), .bus(b0.master));
    gate_vector_checker #(.HOLD_CYCLES(2)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    localparam int S0_LAT = 17, S0_ERR = 1, S0_VEC = 3;
    localparam int S1_LAT = 5,  S1_ERR = 1, S1_VEC = 0;
    localparam int RST_MODE = 0, RST_ERR = 0;
`else
    localparam int S0_LAT = 33, S0_ERR = 1, S0_VEC = 7;
    localparam int S1_LAT = 33, S1_ERR = 7, S1_VEC = 7;
    localparam int RST_MODE = 1, RST_ERR = 1;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] cur_vec(input int sel);
        if (sel == 1) return {b1.vec_a, b1.vec_b, b1.vec_c};
        return {b0.vec_a, b0.vec_b, b0.vec_c};
    endfunction

    // {done, busy, err_count, fail_valid, vec}
    function automatic logic [9:0] snap(input int sel);
        if (sel == 1) return {b1.done, b1.busy, b1.err_count, b1.fail_valid, cur_vec(1)};
        return {b0.done, b0.busy, b0.err_count, b0.fail_valid, cur_vec(0)};
    endfunction

    // {pass, fail_vec, snap}
    function automatic logic [13:0] full(input int sel);
        if (sel == 1) return {b1.pass, b1.fail_vec, snap(1)};
        return {b0.pass, b0.fail_vec, snap(0)};
    endfunction

    // Pulses start, then walks cycle k = 1.. after the accepting edge until done.
    task automatic run(input int sel, input int pulse_at, input int abort_at,
                       output int lat, output int vec_bad, output logic [9:0] first);
        int h;
        h = (sel == 1) ? 2 : 4;
        @(negedge clk);
        if (sel == 1) b1.start = 1'b1; else b0.start = 1'b1;
        @(posedge clk); #1;
        b0.start = 1'b0;
        b1.start = 1'b0;
        vec_bad = 0;
        first = snap(sel);
        lat = 999;
        for (int k = 1; k <= 200; k++) begin
            if ((sel == 1) ? b1.done : b0.done) begin
                lat = k;
                return;
            end
            if (k == abort_at) begin
                lat = k;
                return;
            end
            if (cur_vec(sel) != 3'((k - 1) / h)) vec_bad++;
            b0.start = (sel == 0) && (k == pulse_at);
            @(posedge clk); #1;
        end
        b0.start = 1'b0;
    endtask

    int         lat;
    int         vbad;
    logic [9:0] first;

    initial begin
        b0.start = 1'b0;
        b1.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dut0", full(0), 0);
        chk("reset_dut1", full(1), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_hold", full(0), 0);

        // Golden gate, default hold
        mode = 0;
        run(0, 0, 0, lat, vbad, first);
        chk("golden_first", first, 10'b01_0000_0_000);
        chk("golden_lat", lat, 33);
        chk("golden_vec_seq", vbad, 0);
        chk("golden_result", full(0), 14'b1_000_10_0000_0_111);

        // Stuck-at-0
        mode = 1;
        run(0, 0, 0, lat, vbad, first);
        chk("s0_lat", lat, S0_LAT);
        chk("s0_err", b0.err_count, S0_ERR);
        chk("s0_fail_vec", {b0.fail_valid, b0.fail_vec}, 4'b1_011);
        chk("s0_pass", {b0.pass, b0.busy}, 2'b00);
        chk("s0_vec", cur_vec(0), S0_VEC);

        // Stuck-at-1
        mode = 2;
        run(0, 0, 0, lat, vbad, first);
        chk("s1_lat", lat, S1_LAT);
        chk("s1_err", b0.err_count, S1_ERR);
        chk("s1_fail_vec", {b0.fail_valid, b0.fail_vec}, 4'b1_000);
        chk("s1_pass", b0.pass, 0);
        chk("s1_vec", cur_vec(0), S1_VEC);
        chk("s1_vec_seq", vbad, 0);

        // Start in DONE restarts cleanly
        mode = 0;
        run(0, 0, 0, lat, vbad, first);
        chk("restart_first", first, 10'b01_0000_0_000);
        chk("restart_lat", lat, 33);
        chk("restart_pass", {b0.pass, b0.err_count, b0.fail_valid}, 6'b1_0000_0);

        // Start while busy is ignored
        run(0, 10, 0, lat, vbad, first);
        chk("busy_start_lat", lat, 33);
        chk("busy_start_vec_seq", vbad, 0);
        chk("busy_start_pass", b0.pass, 1);

        // Two-cycle hold instance
        run(1, 0, 0, lat, vbad, first);
        chk("h2_first", first, 10'b01_0000_0_000);
        chk("h2_lat", lat, 17);
        chk("h2_vec_seq", vbad, 0);
        chk("h2_result", full(1), 14'b1_000_10_0000_0_111);

        // Reset while vector 4 is being driven
        mode = RST_MODE;
        run(0, 0, 18, lat, vbad, first);
        chk("pre_rst_vec", cur_vec(0), 4);
        chk("pre_rst_err", b0.err_count, RST_ERR);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst", full(0), 0);
        mode = 0;
        run(0, 0, 0, lat, vbad, first);
        chk("post_rst_lat", lat, 33);
        chk("post_rst_result", full(0), 14'b1_000_10_0000_0_111);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
